pulse_capture_buffer: RTL and testbench

PULSE_CAPTURE_BUFFER -- requirements
Module: pulse_capture_buffer

---
 rtl/pulse_capture_pkg.sv | 49 ++++
 rtl/pulse_capture_buffer_if.sv | 65 ++++++
 rtl/capture_fifo.sv | 74 +++++++
 rtl/pulse_capture_buffer.sv | 245 ++++++++++++++++++++++++
 tb/tb_pulse_capture_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse capture buffer: register map, STATUS bit
// positions, CTRL bit positions and the AXI-Lite write/read FSM encodings.
package pulse_capture_pkg;

  // Register map (byte addresses on the 4-bit AXI-Lite address bus).
  localparam logic [3:0] ADDR_CTRL      = 4'h0;
  localparam logic [3:0] ADDR_STATUS    = 4'h4;
  localparam logic [3:0] ADDR_DATA      = 4'h8;
  localparam logic [3:0] ADDR_OVF_COUNT = 4'hC;

  // CTRL bits. CLEAR is a pulse: it acts on the write and never reads back.
  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  // STATUS layout: {FULL, EMPTY, OVF, ARMED, 15'b0, COUNT[12:0]}.
  localparam int STAT_FULL_BIT  = 31;
  localparam int STAT_EMPTY_BIT = 30;
  localparam int STAT_OVF_BIT   = 29;
  localparam int STAT_ARMED_BIT = 28;
  localparam int STAT_COUNT_W   = 13;

  // DATA read word: sample byte plus a flag saying an entry was really popped.
  localparam int DATA_VALID_BIT = 8;

  typedef enum logic [1:0] {
    WRRESET = 2'd0,
    WRIDLE  = 2'd1,
    WRDATA  = 2'd2,
    WRRESP  = 2'd3
  } wr_state_t;

  // RDWAIT is only visited when the read data path carries an extra stage.
  typedef enum logic [1:0] {
    RDRESET = 2'd0,
    RDIDLE  = 2'd1,
    RDWAIT  = 2'd2,
    RDDATA  = 2'd3
  } rd_state_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/pulse_capture_buffer_if.sv
// Bus bundle for the pulse capture buffer: the AV-ST sample stream from the
// pulse generator and the AXI-Lite control/readout port. The master modport
// is the side driving requests (bus master + upstream source); slave is the
// capture block.
interface pulse_capture_buffer_if;

  // AV-ST sample stream
  logic        S_AVST_VALID;
  logic [7:0]  S_AVST_DATA;
  logic        S_AVST_READY;

  // AXI-Lite write address / data / response
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;

  // AXI-Lite read address / data
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AVST_VALID, S_AVST_DATA,
    input  S_AVST_READY,
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AVST_VALID, S_AVST_DATA,
    output S_AVST_READY,
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/capture_fifo.sv
// Capture storage: circular buffer of DEPTH entries with log2(DEPTH)-bit
// pointers, an occupancy counter that tops out at DEPTH, and a synchronous
// read port whose output register loads the head entry on each pop.
// CLEAR empties the buffer in one cycle and overrides push/pop.
module capture_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_q,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop frees the slot the same cycle, so a push into a full buffer is
  // accepted when it coincides with a pop. CLEAR overrides both.
  assign w_pop   = i_pop  & ~w_empty & ~i_clear;
  assign w_push  = i_push & (~w_full | w_pop) & ~i_clear;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block ordering.
    if (!i_rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write and registered read of the head entry on pop.
  always_ff @(posedge i_clk) begin
    // NOTE: the array and its read register are deliberately left out of
    // reset; a reset term here would stop the array mapping onto block RAM,
    // and pointers/count already make stale contents unreachable.
    if (i_rst_n && w_push) r_mem[r_wr_ptr] <= i_data;
    if (i_rst_n && w_pop)  r_q <= r_mem[r_rd_ptr];
  end

  assign o_q     = r_q;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/pulse_capture_buffer.sv
// Pulse capture buffer top: accepts 8-bit samples on an AV-ST stream while
// armed, stores them in capture_fifo and exposes control, status and a
// pop-on-read DATA register over AXI-Lite.
// Build option: define PULSE_CAPTURE_OVF_COUNT_EN to add a 32-bit saturating
// dropped-beat counter at OVF_COUNT (0xC); otherwise 0xC reads zero.
module pulse_capture_buffer
  import pulse_capture_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int PIPELINE_READ = 1
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  pulse_capture_buffer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  wr_state_t     r_wr_state;
  wr_state_t     w_wr_state_next;
  rd_state_t     r_rd_state;
  rd_state_t     w_rd_state_next;

  logic [3:0]    r_wr_addr;
  logic [3:0]    r_rd_addr;
  logic          r_armed;
  logic          r_ovf;
  logic          r_avst_ready;
  logic          r_rd_popped;
  logic [31:0]   r_rd_snap;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_ar_hs;
  logic          w_ctrl_wr;
  logic          w_clear;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_fifo_q;
  logic [31:0]   w_wdata_masked;
  logic [31:0]   w_status;
  logic [31:0]   w_reg_value;
  logic [31:0]   w_rdata_now;
  logic [31:0]   w_rdata_out;
  logic [31:0]   w_ovf_count_rd;
  logic          w_unused_ok;

  // ---------------------------------------------------------------------------
  // AXI-Lite write path
  // ---------------------------------------------------------------------------
  assign w_aw_hs = (r_wr_state == WRIDLE) & bus.S_AXI_AWVALID;
  assign w_w_hs  = (r_wr_state == WRDATA) & bus.S_AXI_WVALID;

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_wr_state <= WRRESET;
    else                r_wr_state <= w_wr_state_next;
  end

  // Write FSM next-state: address, then data, then response.
  always_comb begin
    // NOTE: default assignment first so every path assigns the output and no
    // latch is inferred for combinational signals.
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      WRRESET: w_wr_state_next = WRIDLE;
      WRIDLE:  if (bus.S_AXI_AWVALID) w_wr_state_next = WRDATA;
      WRDATA:  if (bus.S_AXI_WVALID)  w_wr_state_next = WRRESP;
      WRRESP:  if (bus.S_AXI_BREADY)  w_wr_state_next = WRIDLE;
      default: w_wr_state_next = WRRESET;
    endcase
  end

  // Latch the write address at the AW handshake.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_wr_addr <= '0;
    else if (w_aw_hs)   r_wr_addr <= bus.S_AXI_AWADDR;
  end

  assign w_wdata_masked = bus.S_AXI_WDATA & strb_mask(bus.S_AXI_WSTRB);
  assign w_ctrl_wr      = w_w_hs & (r_wr_addr == ADDR_CTRL) & bus.S_AXI_WSTRB[0];
  assign w_clear        = w_ctrl_wr & w_wdata_masked[CTRL_CLEAR_BIT];

  // ARM follows the last CTRL write; CLEAR never touches it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_armed <= 1'b0;
    else if (w_ctrl_wr) r_armed <= w_wdata_masked[CTRL_ARM_BIT];
  end

  assign bus.S_AXI_AWREADY = (r_wr_state == WRIDLE);
  assign bus.S_AXI_WREADY  = (r_wr_state == WRDATA);
  assign bus.S_AXI_BVALID  = (r_wr_state == WRRESP);
  assign bus.S_AXI_BRESP   = 2'b00;

  // ---------------------------------------------------------------------------
  // Sample capture
  // ---------------------------------------------------------------------------
  assign w_push = bus.S_AVST_VALID & r_armed & (~w_full | w_pop);
  assign w_drop = bus.S_AVST_VALID & r_armed & w_full & ~w_pop;

  capture_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (bus.S_AVST_DATA),
    .o_q     (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sticky overflow: set by a dropped beat, cleared only by CLEAR or reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN || w_clear) r_ovf <= 1'b0;
    else if (w_drop)               r_ovf <= 1'b1;
  end

  // Registered capture-ready to the pulse generator.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_avst_ready <= 1'b0;
    else                r_avst_ready <= r_armed & ~w_full;
  end

  assign bus.S_AVST_READY = r_avst_ready;

`ifdef PULSE_CAPTURE_OVF_COUNT_EN
  logic [31:0] r_ovf_count;

  // Dropped-beat counter, saturating at all-ones.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN || w_clear)        r_ovf_count <= '0;
    else if (w_drop && r_ovf_count != '1) r_ovf_count <= r_ovf_count + 32'd1;
  end

  assign w_ovf_count_rd = r_ovf_count;
`else
  assign w_ovf_count_rd = '0;
`endif

  // ---------------------------------------------------------------------------
  // AXI-Lite read path
  // ---------------------------------------------------------------------------
  assign w_ar_hs = (r_rd_state == RDIDLE) & bus.S_AXI_ARVALID;
  // DATA pops at the AR handshake; an empty buffer or a same-cycle CLEAR
  // means nothing is popped and the read returns zero.
  assign w_pop   = w_ar_hs & (bus.S_AXI_ARADDR == ADDR_DATA) & ~w_empty & ~w_clear;

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) r_rd_state <= RDRESET;
    else                r_rd_state <= w_rd_state_next;
  end

  // Read FSM next-state: optional wait stage, then hold data until accepted.
  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      RDRESET: w_rd_state_next = RDIDLE;
      RDIDLE:  if (bus.S_AXI_ARVALID)
                 w_rd_state_next = (PIPELINE_READ != 0) ? RDWAIT : RDDATA;
      RDWAIT:  w_rd_state_next = RDDATA;
      RDDATA:  if (bus.S_AXI_RREADY) w_rd_state_next = RDIDLE;
      default: w_rd_state_next = RDRESET;
    endcase
  end

  // STATUS word assembled from live state.
  always_comb begin
    w_status                       = '0;
    w_status[STAT_FULL_BIT]        = w_full;
    w_status[STAT_EMPTY_BIT]       = w_empty;
    w_status[STAT_OVF_BIT]         = r_ovf;
    w_status[STAT_ARMED_BIT]       = r_armed;
    w_status[STAT_COUNT_W-1:0]     = STAT_COUNT_W'(w_count);
  end

  // Register read mux for everything except the popped DATA byte.
  always_comb begin
    w_reg_value = '0;
    case (bus.S_AXI_ARADDR)
      ADDR_CTRL:      w_reg_value[CTRL_ARM_BIT] = r_armed;
      ADDR_STATUS:    w_reg_value = w_status;
      ADDR_OVF_COUNT: w_reg_value = w_ovf_count_rd;
      default:        w_reg_value = '0;
    endcase
  end

  // Snapshot address, register value and pop outcome at the AR handshake so
  // RDATA stays stable for the whole data phase.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_rd_addr   <= '0;
      r_rd_snap   <= '0;
      r_rd_popped <= 1'b0;
    end else if (w_ar_hs) begin
      r_rd_addr   <= bus.S_AXI_ARADDR;
      r_rd_snap   <= w_reg_value;
      r_rd_popped <= w_pop;
    end
  end

  // The FIFO read register holds the popped byte until the next pop.
  always_comb begin
    w_rdata_now = r_rd_snap;
    if (r_rd_addr == ADDR_DATA) begin
      w_rdata_now = '0;
      if (r_rd_popped) begin
        w_rdata_now[7:0]            = w_fifo_q;
        w_rdata_now[DATA_VALID_BIT] = 1'b1;
      end
    end
  end

  if (PIPELINE_READ != 0) begin : g_rd_pipe
    logic [31:0] r_rdata_pipe;

    // Extra read stage: capture the composed word one cycle after AR.
    always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN)              r_rdata_pipe <= '0;
      else if (r_rd_state == RDWAIT)   r_rdata_pipe <= w_rdata_now;
    end

    assign w_rdata_out = r_rdata_pipe;
  end else begin : g_rd_direct
    assign w_rdata_out = w_rdata_now;
  end

  assign bus.S_AXI_ARREADY = (r_rd_state == RDIDLE);
  assign bus.S_AXI_RVALID  = (r_rd_state == RDDATA);
  assign bus.S_AXI_RDATA   = w_rdata_out;
  assign bus.S_AXI_RRESP   = 2'b00;

  // Protection bits and the upper write-data bytes carry no meaning here.
  assign w_unused_ok = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT, w_wdata_masked[31:2]};

endmodule

// File: tb/tb_pulse_capture_buffer.sv
// Directed self-checking bench for pulse_capture_buffer (DEPTH=256,
// PIPELINE_READ=1). Inputs change on the falling edge; outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_pulse_capture_buffer;

  localparam int P_DEPTH = 256;
  localparam int P_PIPE  = 1;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_DATA   = 4'h8;
  localparam logic [3:0] A_OVFCNT = 4'hC;

`ifdef PULSE_CAPTURE_OVF_COUNT_EN
  localparam logic [31:0] EXP_OVF4 = 32'd4;
`else
  localparam logic [31:0] EXP_OVF4 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pulse_capture_buffer_if bus ();

  pulse_capture_buffer #(
    .DEPTH         (P_DEPTH),
    .PIPELINE_READ (P_PIPE)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd;
  int          lat;
  logic [31:0] hold_d;
  logic        hold_arready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.S_AXI_AWREADY;
      1:       return bus.S_AXI_WREADY;
      2:       return bus.S_AXI_BVALID;
      3:       return bus.S_AXI_ARREADY;
      4:       return bus.S_AXI_RVALID;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) on a falling edge until the selected handshake signal is high.
  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, sig(which)}, 32'd1);
  endtask

  // Full AXI-Lite write; optionally present one sample beat on the W handshake edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic beat_en,
                           input logic [7:0] beat);
    @(negedge clk);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    wait_sig(0, "awready");
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    wait_sig(1, "wready");
    if (beat_en) begin
      bus.S_AVST_VALID = 1'b1;
      bus.S_AVST_DATA  = beat;
    end
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AVST_VALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    wait_sig(2, "bvalid");
    check("bresp", {30'b0, bus.S_AXI_BRESP}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
  endtask

  // Full AXI-Lite read; RREADY is held low for one extra cycle so the bench
  // can observe RDATA/ARREADY while the data phase is stalled.
  task automatic axi_read(input logic [3:0] addr, input logic beat_en,
                          input logic [7:0] beat, output logic [31:0] data,
                          output int latency);
    @(negedge clk);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    wait_sig(3, "arready");
    if (beat_en) begin
      bus.S_AVST_VALID = 1'b1;
      bus.S_AVST_DATA  = beat;
    end
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AVST_VALID  = 1'b0;
    latency = 1;
    while (!bus.S_AXI_RVALID && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    check("rvalid", {31'b0, bus.S_AXI_RVALID}, 32'd1);
    data = bus.S_AXI_RDATA;
    @(negedge clk);
    hold_d       = bus.S_AXI_RDATA;
    hold_arready = bus.S_AXI_ARREADY;
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  // Stream n consecutive beats start, start+1, ...
  task automatic push_burst(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.S_AVST_VALID = 1'b1;
      bus.S_AVST_DATA  = start + 8'(i);
    end
    @(negedge clk);
    bus.S_AVST_VALID = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.S_AVST_VALID  = 1'b0;
    bus.S_AVST_DATA   = 8'h00;
    bus.S_AXI_AWADDR  = 4'h0;
    bus.S_AXI_AWPROT  = 3'b000;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = 32'h0;
    bus.S_AXI_WSTRB   = 4'h0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = 4'h0;
    bus.S_AXI_ARPROT  = 3'b000;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_handshake_outs",
          {27'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
           bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 32'h0);
    check("rst_avst_ready", {31'b0, bus.S_AVST_READY}, 32'd0);
    rst_n = 1'b1;

    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_after_reset", rd, 32'h4000_0000);
    check("read_latency", lat, 1 + P_PIPE);
    check("rresp", {30'b0, bus.S_AXI_RRESP}, 32'd0);
    check("arready_low_in_rddata", {31'b0, hold_arready}, 32'd0);
    check("avst_ready_unarmed", {31'b0, bus.S_AVST_READY}, 32'd0);

    // Arm and capture ten bytes
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, 8'h00);
    @(negedge clk);
    check("avst_ready_armed", {31'b0, bus.S_AVST_READY}, 32'd1);
    push_burst(8'h00, 10);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_count10", rd, 32'h1000_000A);
    for (int i = 0; i < 10; i++) begin
      axi_read(A_DATA, 1'b0, 8'h00, rd, lat);
      check($sformatf("data_pop%0d", i), rd, 32'h100 + 32'(i));
      check($sformatf("data_hold%0d", i), hold_d, 32'h100 + 32'(i));
    end
    check("data_latency", lat, 1 + P_PIPE);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_drained", rd, 32'h5000_0000);
    axi_read(A_DATA, 1'b0, 8'h00, rd, lat);
    check("data_read_empty", rd, 32'h0);

    // Overfill: 256 stored, 4 dropped
    push_burst(8'h00, 260);
    @(negedge clk);
    check("avst_ready_full", {31'b0, bus.S_AVST_READY}, 32'd0);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_full_ovf", rd, 32'hB000_0100);
    axi_read(A_OVFCNT, 1'b0, 8'h00, rd, lat);
    check("ovf_count_4", rd, EXP_OVF4);

    // Push coincident with pop on a full buffer
    axi_read(A_DATA, 1'b1, 8'hAA, rd, lat);
    check("pop_full_oldest", rd, 32'h0000_0100);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_push_pop_full", rd, 32'hB000_0100);
    axi_read(A_OVFCNT, 1'b0, 8'h00, rd, lat);
    check("ovf_count_unchanged", rd, EXP_OVF4);
    axi_read(A_DATA, 1'b0, 8'h00, rd, lat);
    check("pop_second_oldest", rd, 32'h0000_0101);

    // Disarm: further beats are discarded silently
    axi_write(A_CTRL, 32'h0, 4'hF, 1'b0, 8'h00);
    push_burst(8'h40, 5);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_disarmed", rd, 32'h2000_00FF);
    check("avst_ready_disarmed", {31'b0, bus.S_AVST_READY}, 32'd0);

    // Re-arm, then CLEAR with a beat on the same edge
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, 8'h00);
    axi_write(A_CTRL, 32'h3, 4'hF, 1'b1, 8'h55);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_after_clear", rd, 32'h5000_0000);
    axi_read(A_OVFCNT, 1'b0, 8'h00, rd, lat);
    check("ovf_count_cleared", rd, 32'h0);
    axi_read(A_DATA, 1'b0, 8'h00, rd, lat);
    check("data_after_clear", rd, 32'h0);
    check("avst_ready_after_clear", {31'b0, bus.S_AVST_READY}, 32'd1);

    // Strobe masking and ignored addresses
    push_burst(8'h11, 3);
    axi_write(A_CTRL, 32'h0, 4'h0, 1'b0, 8'h00);
    axi_write(A_CTRL, 32'h0, 4'hE, 1'b0, 8'h00);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_strb_masked", rd, 32'h1000_0003);
    axi_read(A_DATA, 1'b0, 8'h00, rd, lat);
    check("data_after_strb", rd, 32'h0000_0111);
    axi_write(A_DATA, 32'hFFFF_FFFF, 4'hF, 1'b0, 8'h00);
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_ro_write_ignored", rd, 32'h1000_0002);
    axi_read(4'h1, 1'b0, 8'h00, rd, lat);
    check("unmapped_read_zero", rd, 32'h0);

    // Reset asserted while an AR and a beat are being presented
    @(negedge clk);
    bus.S_AXI_ARADDR  = A_DATA;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AVST_VALID  = 1'b1;
    bus.S_AVST_DATA   = 8'h77;
    rst_n             = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AVST_VALID  = 1'b0;
    check("midreset_outs",
          {27'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
           bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 32'h0);
    rst_n = 1'b1;
    axi_read(A_STATUS, 1'b0, 8'h00, rd, lat);
    check("status_after_midreset", rd, 32'h4000_0000);
    check("avst_ready_after_midreset", {31'b0, bus.S_AVST_READY}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
